microsequencer: RTL
===================

Name: microsequencer

Overview:
- Next-state engine for the microprogrammed control unit. Owns the state register that drives the microstore address input, so it is the producer side of the microstore's state-in / signals-out interface.
- Each cycle it selects the next microstate from the microword's next-state control field and branch address, plus the instruction opcode, condition flag and memory-complete handshake.

Parameters:
- STATE_W, 7, width of the state number (matches microstore address width).
- FETCH_STATE, 7'd1, first fetch microstate, target of RETURN mode.
- MOC_TIMEOUT, 15, cycles allowed in a MOC wait before timeout (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ns_ctl  input  3  next-state mode from the current microword.
- cr_addr  input  7  branch/jump target from the current microword.
- inv  input  1  invert the condition for CBRANCH.
- cond  input  1  condition flag (e.g. ALU zero).
- opcode  input  6  opcode of the instruction register.
- moc  input  1  memory operation complete, level-sensitive.
- current_state  output  7  registered state, fed to the microstore.
- illegal_op  output  1  registered one-cycle pulse on an unmapped opcode dispatch.
- stall  output  1  combinational; high while WAIT_MOC mode is active and moc=0.
- moc_timeout  output  1  sticky error flag (optional feature); tied 0 when compiled out.

Behaviour:
- Reset (reset=0, asynchronous): current_state=0, illegal_op=0, moc_timeout=0, wait counter=0. Reset dominates every other input.
- All state updates occur on the rising edge of clk. current_state changes one cycle after the inputs that select it.
- ns_ctl modes:
  - 000 DISPATCH: next state is the encoder output for opcode.
  - 001 JUMP: next = cr_addr.
  - 010 INC: next = current_state+1, modulo 128 (127 wraps to 0).
  - 011 CBRANCH: next = cr_addr if (cond XOR inv) is 1, else current_state+1.
  - 100 WAIT_MOC: next = current_state+1 if moc=1, else hold current_state.
  - 101 RETURN: next = FETCH_STATE.
  - 110 and 111: next = 0 (recovery to the reset state).
- Encoder map:
  - 6'h00 → 10
  - 6'h08 → 11
  - 6'h23 → 12
  - 6'h2B → 16
  - 6'h04 → 20
  - 6'h02 → 24
  - Any other opcode → 0, and illegal_op=1 for exactly the following cycle.
- illegal_op is asserted only in DISPATCH mode. Back-to-back illegal dispatches give a pulse on each cycle.
- stall is combinational from ns_ctl and moc; it carries no latency.
- moc is sampled only in WAIT_MOC mode and ignored in every other mode.
- In CBRANCH mode, when cr_addr equals current_state+1 the taken and not-taken paths give the same result; no special handling.

Optional Feature:
- Macro: MICROSEQ_MOC_TIMEOUT_EN.
- With the macro defined:
  - A 4-bit wait counter increments on every WAIT_MOC cycle with moc=0.
  - The counter clears on leaving WAIT_MOC or on moc=1.
  - When the counter reaches MOC_TIMEOUT: next = 0, moc_timeout is set and stays set until reset, and the counter clears.
  - moc=1 on the timeout cycle wins: the sequencer advances normally and moc_timeout is not set.
- Without the macro: no counter is built, WAIT_MOC holds indefinitely, and moc_timeout is constant 0.

Decomposition:
- Package microseq_pkg holds:
  - ns_ctl encodings (NS_DISPATCH, NS_JUMP, NS_INC, NS_CBRANCH, NS_WAIT_MOC, NS_RETURN);
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - dispatch-state constants (S_RTYPE=10, S_ADDI=11, S_LW=12, S_SW=16, S_BEQ=20, S_J=24, S_RESET=0).
- One sub-module, microseq_encoder: purely combinational, maps opcode to (target state, illegal flag).
- Top level contains the next-state mux, the state register, the pulse register and the optional timeout counter.

Test Plan:
- Reset: assert reset=0 mid-run with current_state=37 → current_state=0 immediately, without waiting for a clock edge. Release, then drive ns_ctl=RETURN → state 1 after the next edge.
- DISPATCH: opcode 6'h23 → 12; 6'h2B → 16; 6'h3F → 0 with illegal_op high for exactly one cycle.
- CBRANCH: state 20, cr_addr=30:
  - cond=1, inv=0 → 30;
  - cond=1, inv=1 → 21;
  - cond=0, inv=1 → 30.
- INC wrap: state 127, ns_ctl=INC → 0.
- WAIT_MOC: state 13, moc=0 for 3 cycles → state holds at 13 with stall=1. Then moc=1 → 14 and stall=0.
- Timeout (macro on, MOC_TIMEOUT=15): moc held 0 in WAIT_MOC → state 0 after 15 wait cycles and moc_timeout stays 1 until reset. Same stimulus with moc=1 on cycle 15 → state advances by one and moc_timeout stays 0.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-state modes, opcodes and
// the dispatch target microstates.
package microseq_pkg;

  typedef enum logic [2:0] {
    NS_DISPATCH  = 3'b000,
    NS_JUMP      = 3'b001,
    NS_INC       = 3'b010,
    NS_CBRANCH   = 3'b011,
    NS_WAIT_MOC  = 3'b100,
    NS_RETURN    = 3'b101,
    NS_RECOVER_A = 3'b110,
    NS_RECOVER_B = 3'b111
  } ns_ctl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [6:0] S_RESET = 7'd0;
  localparam logic [6:0] S_RTYPE = 7'd10;
  localparam logic [6:0] S_ADDI  = 7'd11;
  localparam logic [6:0] S_LW    = 7'd12;
  localparam logic [6:0] S_SW    = 7'd16;
  localparam logic [6:0] S_BEQ   = 7'd20;
  localparam logic [6:0] S_J     = 7'd24;

endpackage

// File: rtl/microseq_encoder.sv
// Opcode dispatch encoder: maps an instruction opcode to the first
// microstate of its execution sequence, flagging unmapped opcodes.
module microseq_encoder
  import microseq_pkg::*;
#(
  parameter int unsigned STATE_W = 7
) (
  input  logic [5:0]         opcode,
  output logic [STATE_W-1:0] target,
  output logic               illegal
);

  // Opcode lookup; unmapped opcodes fall back to the reset state.
  always_comb begin
    target  = STATE_W'(S_RESET);
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: target = STATE_W'(S_RTYPE);
      OP_ADDI:  target = STATE_W'(S_ADDI);
      OP_LW:    target = STATE_W'(S_LW);
      OP_SW:    target = STATE_W'(S_SW);
      OP_BEQ:   target = STATE_W'(S_BEQ);
      OP_J:     target = STATE_W'(S_J);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: owns the microstate register feeding the microstore and
// selects the next microstate from the microword's next-state control.
// Optional MOC wait timeout is built when MICROSEQ_MOC_TIMEOUT_EN is defined.
module microsequencer
  import microseq_pkg::*;
#(
  parameter int unsigned         STATE_W     = 7,
  parameter logic [STATE_W-1:0]  FETCH_STATE = 7'd1,
  parameter int unsigned         MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_ctl,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic               inv,
  input  logic               cond,
  input  logic [5:0]         opcode,
  input  logic               moc,
  output logic [STATE_W-1:0] current_state,
  output logic               illegal_op,
  output logic               stall,
  output logic               moc_timeout
);

  logic [STATE_W-1:0] enc_target;
  logic               enc_illegal;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] state_d;
  logic               illegal_d;
  logic               timeout_hit;

  microseq_encoder #(
    .STATE_W (STATE_W)
  ) u_encoder (
    .opcode  (opcode),
    .target  (enc_target),
    .illegal (enc_illegal)
  );

  assign stall = (ns_ctl == NS_WAIT_MOC) && !moc;

`ifdef MICROSEQ_MOC_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_inc;
  logic       timeout_flag;

  assign wait_cnt_inc = wait_cnt + 4'd1;
  // Fires on the wait cycle that brings the count to the limit; a moc=1
  // on that same cycle deasserts stall and therefore wins.
  assign timeout_hit  = stall && (wait_cnt_inc == 4'(MOC_TIMEOUT));
  assign moc_timeout  = timeout_flag;

  // Count consecutive stalled wait cycles; latch the sticky timeout error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (!stall || timeout_hit) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt_inc;
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  // Parameter has no hardware without the timeout logic.
  logic unused_moc_timeout_cfg;
  assign unused_moc_timeout_cfg = ^(32'(MOC_TIMEOUT));
  assign timeout_hit = 1'b0;
  assign moc_timeout = 1'b0;
`endif

  // Next-state selection from the microword's next-state mode.
  always_comb begin
    state_inc = current_state + STATE_W'(1);
    state_d   = STATE_W'(S_RESET);
    illegal_d = 1'b0;
    case (ns_ctl)
      NS_DISPATCH: begin
        state_d   = enc_target;
        illegal_d = enc_illegal;
      end
      NS_JUMP:     state_d = cr_addr;
      NS_INC:      state_d = state_inc;
      NS_CBRANCH:  state_d = (cond ^ inv) ? cr_addr : state_inc;
      NS_WAIT_MOC: state_d = moc ? state_inc : current_state;
      NS_RETURN:   state_d = FETCH_STATE;
      default:     state_d = STATE_W'(S_RESET);
    endcase
    if (timeout_hit) begin
      state_d = STATE_W'(S_RESET);
    end
  end

  // Microstate register and one-cycle illegal-dispatch pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_state <= '0;
      illegal_op    <= 1'b0;
    end else begin
      current_state <= state_d;
      illegal_op    <= illegal_d;
    end
  end

endmodule
